// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory access controller sitting between the pipeline's Memory stage
//   and a word-wide data RAM that completes transactions with a ready
//   handshake. A load or store in M is turned into a single bus transaction
//   with byte enables and lane-replicated store data. The pipeline is stalled
//   until the RAM answers or the wait budget runs out. The raw, unshifted
//   read word is returned on MemDataM for the datapath's load decoder.
//
// Parameters
//   TIMEOUT     : cycles spent waiting for mem_ready before giving up (1..65535)
//
// Ports
//   clk, reset  : clock (rising edge) and asynchronous active-high reset
//   MemReadM    : instruction in M is a load
//   MemWriteM   : instruction in M is a store (wins if both are set)
//   InstrM      : funct3 of the instruction in M (b/h/w/bu/hu)
//   ALUResultM  : byte address of the access
//   WriteDataM  : right-aligned store data
//   MemDataM    : raw read word, valid in the DONE cycle, held otherwise
//   StallMemM   : stall request to the hazard unit
//   MisalignM   : misaligned access seen in IDLE (combinational)
//   BusErrM     : one-cycle registered pulse when the wait budget expires
//   mem_req     : bus request, high for the whole BUSY phase
//   mem_we      : write strobe, qualified by mem_req
//   mem_addr    : word-aligned address
//   mem_wdata   : lane-replicated store data
//   mem_be      : byte enables
//   mem_rdata   : read data, valid with mem_ready
//   mem_ready   : transaction complete
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  InstrM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] MemDataM,
    output logic        StallMemM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value before the access is abandoned.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic        acc;
    logic [1:0]  size;
    logic        misalign;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    logic [15:0] wait_cnt;
    logic        wait_last;
    logic [31:0] data_r;
    logic        bus_err_r;

    logic        req_c;
    logic        stall_c;
    logic        mis_c;
    logic        start;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign acc  = MemReadM | MemWriteM;
    // funct3[1:0] encodes the size for both loads and stores; bit 2 only
    // selects sign handling, which the load decoder downstream deals with.
    assign size = InstrM[1:0];

    always_comb begin
        misalign = 1'b0;
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ALUResultM[0];
            default: misalign = |ALUResultM[1:0];
        endcase
    end

    // Lane steering: store data is replicated across every lane the size
    // could occupy, so the RAM only has to honour the byte enables.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
        case (size)
            2'b00: begin
                be_next    = 4'b0001 << ALUResultM[1:0];
                wdata_next = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_next    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = WriteDataM;
            end
        endcase
    end

    assign wait_last = (wait_cnt == WAIT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        mis_c      = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (misalign) begin
                        mis_c = 1'b1;
                    end else begin
                        // Stall in the issue cycle itself so M holds the
                        // instruction while the request is being launched.
                        stall_c    = 1'b1;
                        start      = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // Stall is Moore here: no path from mem_ready.
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (mem_ready || wait_last) state_next = DONE;
            end
            DONE: begin
                // Always back to IDLE so the instruction is never re-issued.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // state is reset asynchronously, so mem_req falls the moment reset
    // rises. The Mealy stall and misalign terms are masked as well, since
    // the instruction may still be sitting in M while reset is held.
    assign mem_req   = req_c;
    assign StallMemM = stall_c & ~reset;
    assign MisalignM = mis_c & ~reset;
    assign BusErrM   = bus_err_r;
    assign MemDataM  = data_r;

    // ------------------------------------------------------------------
    // Bus request registers: captured on entry to BUSY and held until the
    // next access so the RAM sees stable values for the whole transaction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
        end else if (start) begin
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_wdata <= wdata_next;
            mem_be    <= be_next;
        end
    end

    // ------------------------------------------------------------------
    // Wait counter: zero outside BUSY, so every transaction starts at 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              wait_cnt <= 16'd0;
        else if (state == BUSY) wait_cnt <= wait_cnt + 16'd1;
        else                    wait_cnt <= 16'd0;
    end

    // ------------------------------------------------------------------
    // Read data and bus error. mem_ready takes priority over the timeout
    // when both land in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r    <= 32'd0;
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= 1'b0;
            if (state == BUSY) begin
                if (mem_ready) begin
                    if (!mem_we) data_r <= mem_rdata;
                end else if (wait_last) begin
                    data_r    <= 32'd0;
                    bus_err_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  InstrM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] MemDataM;
    logic        StallMemM;
    logic        MisalignM;
    logic        BusErrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    dmem_ctrl #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .InstrM     (InstrM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemDataM   (MemDataM),
        .StallMemM  (StallMemM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle outputs, written by the stimulus tasks.
    logic        cmp_en;
    logic        exp_req, exp_stall, exp_mis, exp_err, exp_we;
    logic [31:0] exp_data, exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    // Activity observed on the bus, for the literal checks.
    int          req_cnt, stall_cnt, err_cnt, mis_cnt;
    logic        req_q;
    logic [31:0] addr_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  be_q[$];
    logic        we_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single compare process against the model's per-cycle expectations.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_req",   32'(mem_req),   32'(exp_req));
            chk("StallMemM", 32'(StallMemM), 32'(exp_stall));
            chk("MisalignM", 32'(MisalignM), 32'(exp_mis));
            chk("BusErrM",   32'(BusErrM),   32'(exp_err));
            chk("MemDataM",  MemDataM,       exp_data);
            if (exp_req) begin
                chk("mem_addr",  mem_addr,      exp_addr);
                chk("mem_be",    32'(mem_be),   32'(exp_be));
                chk("mem_wdata", mem_wdata,     exp_wdata);
                chk("mem_we",    32'(mem_we),   32'(exp_we));
            end
        end
    end

    always @(negedge clk) begin
        if (mem_req)   req_cnt++;
        if (StallMemM) stall_cnt++;
        if (BusErrM)   err_cnt++;
        if (MisalignM) mis_cnt++;
        if (mem_req && !req_q) begin
            addr_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            be_q.push_back(mem_be);
            we_q.push_back(mem_we);
        end
        req_q = mem_req;
    end

    task automatic clr();
        req_cnt = 0; stall_cnt = 0; err_cnt = 0; mis_cnt = 0;
        addr_q.delete(); wd_q.delete(); be_q.delete(); we_q.delete();
    endtask

    task automatic idle(input int n, input logic stray);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemReadM = 1'b0; MemWriteM = 1'b0;
            mem_ready = stray; mem_rdata = 32'hFEEDFACE;
            exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
        end
    endtask

    // One instruction in M: IDLE cycle, BUSY until ready (cycle rdy_at,
    // 0 = never) or TMO cycles, then DONE. Returns 1ns into the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rdy_at, input logic [31:0] rdata,
                          input logic stray);
        logic [1:0] sz;
        logic       mis, tmo, done;
        int         c;
        sz  = f3[1:0];
        mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; InstrM = f3; ALUResultM = a; WriteDataM = wd;
        mem_ready = stray; mem_rdata = 32'hDEAD0000;
        exp_req = 1'b0; exp_err = 1'b0;
        exp_stall = (rd | wr) & !mis;
        exp_mis   = (rd | wr) & mis;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_we    = wr;
        case (sz)
            2'd0:    begin exp_be = 4'b0001 << a[1:0]; exp_wdata = {4{wd[7:0]}}; end
            2'd1:    begin exp_be = a[1] ? 4'hC : 4'h3; exp_wdata = {2{wd[15:0]}}; end
            default: begin exp_be = 4'hF; exp_wdata = wd; end
        endcase
        if ((rd | wr) && !mis) begin
            c = 0; done = 1'b0; tmo = 1'b0;
            while (!done) begin
                @(posedge clk); #1;
                c++;
                exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0;
                mem_ready = (c == rdy_at); mem_rdata = rdata;
                if (c == rdy_at)   done = 1'b1;
                else if (c == TMO) begin done = 1'b1; tmo = 1'b1; end
            end
            @(posedge clk); #1;
            mem_ready = stray; mem_rdata = 32'h5555AAAA;
            exp_req = 1'b0; exp_stall = 1'b0; exp_err = tmo;
            if (tmo)      exp_data = 32'd0;
            else if (!wr) exp_data = rdata;
        end
    endtask

    initial begin
        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; InstrM = 3'b010;
        ALUResultM = 32'd0; WriteDataM = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
        exp_we = 1'b0; exp_data = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        req_q = 1'b0;
        clr();
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be",    32'(mem_be), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        @(posedge clk); #2; reset = 1'b0;

        // Word load, ready on 2nd BUSY cycle
        clr();
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 2, 32'hCAFEBABE, 1'b0);
        @(negedge clk); #1;
        chk("lw_addr",  addr_q.size() > 0 ? addr_q[0] : 32'hX, 32'h100);
        chk("lw_be",    32'(be_q.size() > 0 ? be_q[0] : 4'hX), 32'hF);
        chk("lw_we",    32'(we_q.size() > 0 ? we_q[0] : 1'bX), 32'd0);
        chk("lw_stall", stall_cnt, 3);
        chk("lw_data",  MemDataM, 32'hCAFEBABE);

        // Byte and half stores
        clr();
        access(1'b0, 1'b1, 3'b000, 32'h203, 32'h12345678, 1, 32'd0, 1'b0);
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 3, 32'd0, 1'b0);
        @(negedge clk); #1;
        chk("st_count", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            chk("sb_addr",  addr_q[0], 32'h200);
            chk("sb_be",    32'(be_q[0]), 32'h8);
            chk("sb_wdata", wd_q[0], 32'h78787878);
            chk("sb_we",    32'(we_q[0]), 32'd1);
            chk("sh_addr",  addr_q[1], 32'h200);
            chk("sh_be",    32'(be_q[1]), 32'hC);
            chk("sh_wdata", wd_q[1], 32'h56785678);
        end
        chk("st_keep_data", MemDataM, 32'hCAFEBABE);

        // Misaligned accesses
        clr();
        access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 1, 32'd0, 1'b0);
        access(1'b0, 1'b1, 3'b001, 32'h103, 32'hABCD, 1, 32'd0, 1'b0);
        idle(1, 1'b0);
        @(negedge clk); #1;
        chk("mis_pulses", mis_cnt, 2);
        chk("mis_req",    req_cnt, 0);
        chk("mis_stall",  stall_cnt, 0);

        // Timeout with mem_ready held low
        clr();
        access(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 0, 32'd0, 1'b0);
        @(negedge clk); #1;
        chk("tmo_req_cycles", req_cnt, 4);
        chk("tmo_err",        err_cnt, 1);
        chk("tmo_data",       MemDataM, 32'd0);
        idle(1, 1'b0);

        // mem_ready on the last allowed cycle wins over the timeout
        clr();
        access(1'b1, 1'b0, 3'b010, 32'h504, 32'd0, 4, 32'h13579BDF, 1'b0);
        @(negedge clk); #1;
        chk("late_req_cycles", req_cnt, 4);
        chk("late_err",        err_cnt, 0);
        chk("late_data",       MemDataM, 32'h13579BDF);
        idle(1, 1'b0);

        // Reset during BUSY
        clr();
        @(posedge clk); #1;
        MemReadM = 1'b1; MemWriteM = 1'b0; InstrM = 3'b010; ALUResultM = 32'h300;
        exp_stall = 1'b1; exp_mis = 1'b0; exp_err = 1'b0; exp_req = 1'b0;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_addr = 32'h300; exp_be = 4'hF; exp_we = 1'b0;
        @(negedge clk); #1;
        cmp_en = 1'b0;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_req",   32'(mem_req), 32'd0);
        chk("rst_async_stall", 32'(StallMemM), 32'd0);
        MemReadM = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_data = 32'd0;
        cmp_en = 1'b1;
        clr();
        access(1'b1, 1'b0, 3'b010, 32'h304, 32'd0, 1, 32'h0BADF00D, 1'b0);
        @(negedge clk); #1;
        chk("post_rst_data", MemDataM, 32'h0BADF00D);
        chk("post_rst_req",  req_cnt, 1);

        // Back-to-back: lw, lw, sw with stray ready pulses in IDLE and DONE
        clr();
        access(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 1, 32'h11112222, 1'b1);
        access(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 2, 32'h33334444, 1'b1);
        access(1'b0, 1'b1, 3'b010, 32'h408, 32'h99990000, 1, 32'd0, 1'b1);
        idle(3, 1'b1);
        @(negedge clk); #1;
        chk("b2b_count", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            chk("b2b_addr0", addr_q[0], 32'h400);
            chk("b2b_addr1", addr_q[1], 32'h404);
            chk("b2b_addr2", addr_q[2], 32'h408);
            chk("b2b_we2",   32'(we_q[2]), 32'd1);
        end
        chk("b2b_req_cycles", req_cnt, 4);
        chk("b2b_data",       MemDataM, 32'h33334444);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
